// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one core-side DMI port between NumReq requesters, one transaction
// outstanding. Optional WAIT watchdog compiled in with `define DMI_ARBITER_WATCHDOG_EN.
module dmi_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024,
  // dmi_req_t packs {addr[6:0], op[1:0], data[31:0]}; dmi_resp_t packs {data[31:0], resp[1:0]}.
  localparam int unsigned ReqW  = 41,
  localparam int unsigned RespW = 34,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*ReqW-1:0] req_i,
  output logic [NumReq-1:0]      resp_valid_o,
  input  logic [NumReq-1:0]      resp_ready_i,
  output logic [RespW-1:0]       resp_o,
  output logic [ReqW-1:0]        dmi_req_o,
  output logic                   dmi_req_valid_o,
  input  logic                   dmi_req_ready_i,
  input  logic [RespW-1:0]       dmi_resp_i,
  input  logic                   dmi_resp_valid_i,
  output logic                   dmi_resp_ready_o,
  output logic [IdxW-1:0]        owner_o,
  output logic                   busy_o,
  output logic                   stray_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [ReqW-1:0]   req_q, req_d;
  logic [RespW-1:0]  resp_q, resp_d;

  logic              grant_found;
  logic [IdxW-1:0]   grant_idx;

`ifdef DMI_ARBITER_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
`endif

  // First valid requester at or above rr_ptr_q, wrapping around.
  always_comb begin
    logic [IdxW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NumReq);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    req_d            = req_q;
    resp_d           = resp_q;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    stray_o          = 1'b0;
`ifdef DMI_ARBITER_WATCHDOG_EN
    cnt_d            = cnt_q;
    timeout_d        = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        dmi_resp_ready_o = 1'b1;
        stray_o          = dmi_resp_valid_i;
        if (grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
          req_d                  = req_i[grant_idx*ReqW +: ReqW];
          owner_d                = grant_idx;
          if (32'(grant_idx) == NumReq - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx + 1'b1;
          end
          state_d = StReq;
        end
      end
      StReq: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = StWait;
`ifdef DMI_ARBITER_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      StWait: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_i;
          state_d = StResp;
`ifdef DMI_ARBITER_WATCHDOG_EN
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          // Abort with a DTM error; a real response in this same cycle takes priority above.
          resp_d    = {32'h0, 2'h2};
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        resp_valid_o[owner_q] = 1'b1;
        if (resp_ready_i[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rst_i) begin
      req_ready_o      = '0;
      resp_valid_o     = '0;
      dmi_req_valid_o  = 1'b0;
      dmi_resp_ready_o = 1'b0;
      stray_o          = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      req_q     <= '0;
      resp_q    <= '0;
`ifdef DMI_ARBITER_WATCHDOG_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      assert (NumReq >= 2 && TimeoutCycles >= 2);
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      resp_q    <= resp_d;
`ifdef DMI_ARBITER_WATCHDOG_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign dmi_req_o = req_q;
  assign resp_o    = resp_q;
  assign owner_o   = owner_q;
  assign busy_o    = (state_q != StIdle) && !rst_i;

`ifdef DMI_ARBITER_WATCHDOG_EN
  assign timeout_o = timeout_q && !rst_i;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Round-robin arbiter and sequencer that shares the core-side DMI request/response port (the `clk_i`-domain side of the JTAG DMI clock-domain crossing) between `NumReq` requesters, for example the JTAG DTM path and an on-chip debug-access path. It keeps exactly one transaction outstanding and routes the response back to the requester that issued it. It also drops stray responses, and can optionally abort a hung transaction with an error response. Everything runs in the debug module's core clock domain.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters; must be ≥2.
- `TimeoutCycles`, default 1024: WAIT-state watchdog limit; must be ≥2. Used only when the watchdog is compiled in.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_ready_o`  out  NumReq  per-requester request ready.
- `req_i`  in  NumReq × `dm::dmi_req_t`  per-requester request (addr/op/data).
- `resp_valid_o`  out  NumReq  per-requester response valid.
- `resp_ready_i`  in  NumReq  per-requester response ready.
- `resp_o`  out  `dm::dmi_resp_t`  response payload, shared by all requesters and qualified by `resp_valid_o`.
- `dmi_req_o`  out  `dm::dmi_req_t`  request to the DMI port.
- `dmi_req_valid_o`  out  1  request valid to the DMI port.
- `dmi_req_ready_i`  in  1  DMI port accepts the request.
- `dmi_resp_i`  in  `dm::dmi_resp_t`  response from the DMI port.
- `dmi_resp_valid_i`  in  1  response valid from the DMI port.
- `dmi_resp_ready_o`  out  1  arbiter accepts the response.
- `owner_o`  out  $clog2(NumReq)  index of the current or last granted requester.
- `busy_o`  out  1  high in any state other than IDLE.
- `stray_o`  out  1  one-cycle pulse when a response is dropped.
- `timeout_o`  out  1  one-cycle pulse when the watchdog aborts a transaction.

## Operation
FSM states: IDLE, REQ, WAIT, RESP.

- **IDLE**
  - Winner = first requester with `req_valid_i` set, searching upward from `rr_ptr` with wrap.
  - `req_ready_o[winner]` = 1 combinationally; all other bits = 0.
  - On handshake: capture `req_i[winner]` into the request register, set `owner` = winner, set `rr_ptr` = (winner+1) mod NumReq, go to REQ.
  - `dmi_resp_ready_o` = 1. Any response accepted in IDLE is discarded and pulses `stray_o`.
- **REQ**
  - `dmi_req_valid_o` = 1 and `dmi_req_o` = the captured request, both held stable until `dmi_req_ready_i`.
  - On handshake: go to WAIT.
  - `dmi_resp_ready_o` = 0.
- **WAIT**
  - `dmi_resp_ready_o` = 1.
  - On `dmi_resp_valid_i`: capture `dmi_resp_i` into the response register, go to RESP.
- **RESP**
  - `resp_valid_o[owner]` = 1 and `resp_o` = the captured response, both held until `resp_ready_i[owner]`; then go to IDLE.
  - `dmi_resp_ready_o` = 0. Ready inputs from non-owners are ignored.
- **Registers:** `resp_o` and `dmi_req_o` are registered. All valid/ready outputs decode from the state; `req_ready_o` additionally depends on `req_valid_i`.
- **Reset:**
  - While `rst_i` = 1, every valid/ready output, `stray_o` and `timeout_o` are forced to 0.
  - On the first clock with `rst_i` = 1: state = IDLE, `rr_ptr` = 0, `owner` = 0, payload registers = 0.
  - Reset mid-transaction abandons it with no response to the requester. Any later response from the DMI port arrives in IDLE and is dropped as stray.

## Timing
- Request handshake in cycle t → `dmi_req_valid_o` = 1 in cycle t+1.
- DMI response handshake in cycle t → `resp_valid_o[owner]` = 1 in cycle t+1.
- Minimum turnaround, back-to-back with zero-wait partners: 4 cycles per transaction.
- A new grant is possible in the cycle after the RESP handshake.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NumReq-1,0.

## Configuration
- Macro `DMI_ARBITER_WATCHDOG_EN`.
- **Defined:**
  - A counter of width $clog2(TimeoutCycles+1) clears on entry to WAIT and increments each WAIT cycle without a response.
  - In the cycle where the count equals TimeoutCycles-1 and no response arrives, the FSM goes to RESP with `resp_o` = {data=0, resp=2'h2} (`dm::DTM_ERR`) and pulses `timeout_o`.
  - If a real response and expiry coincide in the same cycle, the real response wins and `timeout_o` stays 0.
  - A late response after abort arrives in IDLE and is dropped with `stray_o`.
- **Undefined:** no counter is built, `timeout_o` is tied to 0, WAIT waits indefinitely, and `TimeoutCycles` is ignored.

## Test plan
- **Single read:** requester 0 sends op=1 (read), addr=0x11; DMI port ready immediately and responds {data=0xDEADBEEF, resp=0} 3 cycles later → `resp_valid_o` = 2'b01 with that payload. Requester 1 sees no activity.
- **Round-robin:** both requesters continuously valid for 4 transactions → grant order 0,1,0,1. `owner_o` matches each response, and each `resp_valid_o` bit appears only for its issuer.
- **Backpressure:** hold `dmi_req_ready_i` = 0 for 5 cycles and `resp_ready_i[1]` = 0 for 5 cycles → `dmi_req_o` and `resp_o` are stable throughout, and there is no second grant until the RESP handshake.
- **Stray response:** `dmi_resp_valid_i` pulses in IDLE with data 0x1234 → `stray_o` pulses once and no `resp_valid_o` bit is set.
- **Reset mid-transaction:** assert `rst_i` for 1 cycle in WAIT, then deliver the response → all outputs are 0 during reset, state returns to IDLE, and the response is dropped with `stray_o`.
- **Watchdog (macro defined, TimeoutCycles=8):**
  - No response → `timeout_o` pulse and `resp_o` = {0, 2'h2} in cycle WAIT+8.
  - Response exactly in cycle 8 → real data is returned and `timeout_o` = 0.
